ex_buf: RTL and testbench



---
 rtl/ex_buf_pkg.sv | 27 ++
 rtl/ex_buf_pipe_reg.sv | 36 +++
 rtl/ex_buf.sv | 77 +++++++
 tb/tb_ex_buf.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ex_buf_pkg.sv
// Shared definitions for the ID/EX pipeline buffer: control-word field
// indices, the word width and the stage bundle type.
package ex_buf_pkg;

    localparam int unsigned WORD_W = 16;

    localparam int unsigned CTL_ALU_LSB  = 0;
    localparam int unsigned CTL_ALU_MSB  = 3;
    localparam int unsigned CTL_IMM_SEL  = 4;
    localparam int unsigned CTL_MEM_RD   = 5;
    localparam int unsigned CTL_MEM_WR   = 6;
    localparam int unsigned CTL_REG_WR   = 7;
    localparam int unsigned CTL_MEM2REG  = 8;
    localparam int unsigned CTL_DEST_LSB = 12;
    localparam int unsigned CTL_DEST_MSB = 15;

    // Lowest control bit that survives into MEM/WB; everything below is EX-only.
    localparam int unsigned CTL_WB_LSB   = CTL_MEM_RD;

    typedef struct packed {
        logic [WORD_W-1:0] ctl;
        logic [WORD_W-1:0] op2;
        logic [WORD_W-1:0] op1;
        logic [WORD_W-1:0] imm;
    } ex_stage_t;

endpackage : ex_buf_pkg

// File: rtl/ex_buf_pipe_reg.sv
// Width-parameterised pipeline register with asynchronous active-low reset,
// hold and synchronous clear (clear wins over hold).
module pipe_reg #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         hold_i,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_d;
    logic [W-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (clr_i) begin
            data_d = '0;
        end else if (!hold_i) begin
            data_d = d_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule : pipe_reg

// File: rtl/ex_buf.sv
// ID/EX pipeline buffer: registers immediate, operands and the execute control
// word, supports stall (hold) and flush (bubble), and decodes the stored word.
module ex_buf
    import ex_buf_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic [WORD_W-1:0] in_se2,
    input  logic [WORD_W-1:0] in_op1_data,
    input  logic [WORD_W-1:0] in_op2_data,
    input  logic [WORD_W-1:0] in_cntrl_ex,
    output logic [WORD_W-1:0] out_cntrl_wb,
    output logic [WORD_W-1:0] out_op1_m2,
    output logic [WORD_W-1:0] out_op2_m3,
    output logic [WORD_W-1:0] out_imm_m7,
    output logic [WORD_W-1:0] out_ex_haz,
    output logic [3:0]        out_alu_cntrl,
    output logic              out_cntrl_m7
);

    ex_stage_t stage_d;
    ex_stage_t stage_q;

    assign stage_d.imm = in_se2;
    assign stage_d.op1 = in_op1_data;
    assign stage_d.op2 = in_op2_data;
    assign stage_d.ctl = in_cntrl_ex;

    // Flush takes priority over stall inside pipe_reg, so stall+flush is a bubble.
    pipe_reg #(.W(WORD_W)) u_imm_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .hold_i (stall),
        .clr_i  (flush),
        .d_i    (stage_d.imm),
        .q_o    (stage_q.imm)
    );

    pipe_reg #(.W(WORD_W)) u_op1_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .hold_i (stall),
        .clr_i  (flush),
        .d_i    (stage_d.op1),
        .q_o    (stage_q.op1)
    );

    pipe_reg #(.W(WORD_W)) u_op2_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .hold_i (stall),
        .clr_i  (flush),
        .d_i    (stage_d.op2),
        .q_o    (stage_q.op2)
    );

    pipe_reg #(.W(WORD_W)) u_ctl_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .hold_i (stall),
        .clr_i  (flush),
        .d_i    (stage_d.ctl),
        .q_o    (stage_q.ctl)
    );

    assign out_imm_m7    = stage_q.imm;
    assign out_op1_m2    = stage_q.op1;
    assign out_op2_m3    = stage_q.op2;
    assign out_alu_cntrl = stage_q.ctl[CTL_ALU_MSB:CTL_ALU_LSB];
    assign out_cntrl_m7  = stage_q.ctl[CTL_IMM_SEL];
    assign out_cntrl_wb  = {stage_q.ctl[WORD_W-1:CTL_WB_LSB], {CTL_WB_LSB{1'b0}}};
    assign out_ex_haz    = {stage_q.ctl[CTL_REG_WR], stage_q.ctl[CTL_MEM_RD], 10'b0,
                            stage_q.ctl[CTL_DEST_MSB:CTL_DEST_LSB]};

endmodule : ex_buf

// File: tb/tb_ex_buf.sv
// Scoreboard bench for ex_buf: stimulus pushes expected outputs, monitors pop
// and compare one cycle later (or right after an asynchronous reset).
module tb_ex_buf;

    typedef struct {
        string       tag;
        logic [15:0] wb;
        logic [15:0] op1;
        logic [15:0] op2;
        logic [15:0] imm;
        logic [15:0] haz;
        logic [3:0]  alu;
        logic        m7;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic [15:0] in_se2;
    logic [15:0] in_op1_data;
    logic [15:0] in_op2_data;
    logic [15:0] in_cntrl_ex;
    logic [15:0] out_cntrl_wb;
    logic [15:0] out_op1_m2;
    logic [15:0] out_op2_m3;
    logic [15:0] out_imm_m7;
    logic [15:0] out_ex_haz;
    logic [3:0]  out_alu_cntrl;
    logic        out_cntrl_m7;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    exp_t exp_q[$];
    event async_ev;

    // Reference pipeline contents as four plain words.
    logic [15:0] m_imm = '0;
    logic [15:0] m_op1 = '0;
    logic [15:0] m_op2 = '0;
    logic [15:0] m_ctl = '0;

    ex_buf dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .flush         (flush),
        .in_se2        (in_se2),
        .in_op1_data   (in_op1_data),
        .in_op2_data   (in_op2_data),
        .in_cntrl_ex   (in_cntrl_ex),
        .out_cntrl_wb  (out_cntrl_wb),
        .out_op1_m2    (out_op1_m2),
        .out_op2_m3    (out_op2_m3),
        .out_imm_m7    (out_imm_m7),
        .out_ex_haz    (out_ex_haz),
        .out_alu_cntrl (out_alu_cntrl),
        .out_cntrl_m7  (out_cntrl_m7)
    );

    always #5 clk = ~clk;

    function automatic exp_t expect_from_model(string tag);
        exp_t e;
        e.tag = tag;
        e.imm = m_imm;
        e.op1 = m_op1;
        e.op2 = m_op2;
        e.alu = 4'(m_ctl % 16);
        e.m7  = 1'((m_ctl / 16) % 2);
        e.wb  = m_ctl & 16'hFFE0;
        e.haz = 16'(((m_ctl / 128) % 2) * 32768 + ((m_ctl / 32) % 2) * 16384 + m_ctl / 4096);
        return e;
    endfunction

    task automatic check(string name, logic [15:0] act, logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic compare_entry();
        exp_t e;
        e = exp_q.pop_front();
        check({e.tag, ".imm"}, out_imm_m7, e.imm);
        check({e.tag, ".op1"}, out_op1_m2, e.op1);
        check({e.tag, ".op2"}, out_op2_m3, e.op2);
        check({e.tag, ".alu"}, {12'h0, out_alu_cntrl}, {12'h0, e.alu});
        check({e.tag, ".m7"},  {15'h0, out_cntrl_m7}, {15'h0, e.m7});
        check({e.tag, ".wb"},  out_cntrl_wb, e.wb);
        check({e.tag, ".haz"}, out_ex_haz, e.haz);
    endtask

    // Edge monitor: one entry per rising edge that the stimulus described.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) compare_entry();
        end
    end

    // Asynchronous-reset monitor: checks between edges, without a clock.
    initial begin
        forever begin
            @(async_ev);
            #1;
            if (exp_q.size() > 0) compare_entry();
            else begin
                n_cmp++;
                n_bad++;
                $display("FAIL async_entry: got empty queue, expected one entry");
            end
        end
    end

    // Called at a falling edge: drives inputs, advances the model by one
    // rising edge, pushes the expectation, then waits for the next falling edge.
    task automatic step(string tag, logic [15:0] se2, logic [15:0] op1,
                        logic [15:0] op2, logic [15:0] ctl, logic st, logic fl);
        in_se2      = se2;
        in_op1_data = op1;
        in_op2_data = op2;
        in_cntrl_ex = ctl;
        stall       = st;
        flush       = fl;
        if (fl) begin
            m_imm = '0; m_op1 = '0; m_op2 = '0; m_ctl = '0;
        end else if (!st) begin
            m_imm = se2; m_op1 = op1; m_op2 = op2; m_ctl = ctl;
        end
        exp_q.push_back(expect_from_model(tag));
        @(negedge clk);
    endtask

    task automatic rand_step(string tag, logic st, logic fl);
        step(tag, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), st, fl);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        stall       = 1'b0;
        flush       = 1'b0;
        in_se2      = 16'hBEEF;
        in_op1_data = 16'h1234;
        in_op2_data = 16'hA5A5;
        in_cntrl_ex = 16'hFFFF;
        @(negedge clk);
        // Reset held across an edge with arbitrary inputs: model stays zero.
        exp_q.push_back(expect_from_model("reset"));
        @(negedge clk);
        rst_n = 1'b1;

        step("first_load", 16'h000D, 16'h0F0F, 16'h5555, 16'h0030, 1'b0, 1'b0);
        step("load_03A0",  16'h0F0F, 16'h1111, 16'h2222, 16'h03A0, 1'b0, 1'b0);
        step("load_003C",  16'h7777, 16'h3333, 16'h4021, 16'h003C, 1'b0, 1'b0);

        for (int i = 0; i < 3; i++) rand_step("stall", 1'b1, 1'b0);
        rand_step("unstall", 1'b0, 1'b0);
        rand_step("pre_flush", 1'b0, 1'b0);
        rand_step("flush", 1'b0, 1'b1);
        rand_step("reload", 1'b0, 1'b0);
        rand_step("flush_stall", 1'b1, 1'b1);
        rand_step("reload2", 1'b0, 1'b0);

        // Mid-cycle reset assertion must clear without an edge.
        #2;
        rst_n = 1'b0;
        m_imm = '0; m_op1 = '0; m_op2 = '0; m_ctl = '0;
        exp_q.push_back(expect_from_model("async_rst"));
        -> async_ev;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 60; i++) begin
            int unsigned r;
            r = $urandom_range(0, 9);
            rand_step("random", r inside {[0:2]}, r == 3 || r == 4);
        end

        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_ex_buf
